leitor_7segmentos: RTL and testbench
====================================

Name: leitor_7segmentos

Overview:
- Reads the multiplexed seven-segment bus that the display path drives and recovers the hex digits shown on it.
- It is the reader at the far end of the 4-bit-value-to-segment encoding. It samples digit-select plus active-low segment lines, requires a stable pattern, and maps each pattern back to its 4-bit value.
- Recovered digits are kept in per-digit registers with valid flags.
- Used for loopback self-checks of display outputs and for capturing display data from external boards.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (digit-select width).
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is committed (legal values 2..15).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- seg  input  7  segment lines, active-low, bit order 6543210 (g..a)
- dig_sel  input  NUM_DIGITS  digit select, active-high, expected one-hot
- digits  output  4*NUM_DIGITS  recovered values; digit i occupies bits [4i+3:4i]
- digit_valid  output  NUM_DIGITS  1 = digit i holds a decoded value
- update  output  1  one-cycle pulse: a digit register was written
- err  output  1  one-cycle pulse: a stable, one-hot-selected pattern was not in the table
- last_idx  output  clog2(NUM_DIGITS)  index of the last committed or rejected digit

Behaviour:
- Reset (async, rst=1):
  - digits=0, digit_valid=0, update=0, err=0, last_idx=0.
  - Stability counter=0, committed flag=0, sample register=0.
- Sampling:
  - The pair {dig_sel, seg} is registered every edge.
  - If the new pair equals the registered pair, the counter increments, saturating at STABLE_CYCLES-1. Otherwise the counter clears to 0 and the committed flag clears.
- Commit:
  - Occurs on the edge where the counter would reach STABLE_CYCLES-1 and committed=0. At that point the pair has been identical on STABLE_CYCLES consecutive edges.
  - Sets committed=1, so there is exactly one commit per stable window.
  - Outputs are visible after that edge.
  - Latency: pair applied before edge k and held → commit on edge k+STABLE_CYCLES-1.
- Commit action, dig_sel one-hot with index i (last_idx ← i in all three cases):
  - Valid pattern (one of the 16 hex patterns): digits[i] ← value, digit_valid[i] ← 1, update=1 for one cycle.
  - Blank pattern 7'b1111111: digit_valid[i] ← 0, digits[i] unchanged, no update, no err.
  - Any other pattern: digit_valid[i] ← 0, err=1 for one cycle, digits[i] unchanged.
- dig_sel zero or multi-hot: the window still counts, but the commit is silently discarded. No output changes and no pulses.
- Decode table (active-low, 6543210):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- update and err are mutually exclusive. Both are registered and last exactly one cycle.
- A pair that changes mid-window restarts the count, so glitches shorter than STABLE_CYCLES are never committed.
- Re-presenting the same pair after a change produces a new commit. Rewriting an equal value still pulses update.
- Reset mid-window: all state clears immediately. The count restarts from the first edge after rst deasserts.

Decomposition:
- Shared package/include: the 16 segment-pattern constants and SEG_BLANK. The existing display decoder and this block use the same definitions, so encode and decode cannot drift.
- One combinational sub-module, segmentos_para_hex:
  - Input: seg[6:0].
  - Outputs: valor[3:0], eh_valido, eh_branco.
- Everything else (stability counter, one-hot check, digit registers) lives in leitor_7segmentos.

Test Plan:
- Reset with rst=1 mid-operation → all outputs 0 asynchronously, before the next edge.
- dig_sel=0001, seg=0100100 held 4 edges → after 4th edge digits[3:0]=2, digit_valid=0001, update pulses 1 cycle, last_idx=0. Holding 10 more edges gives no further pulses.
- dig_sel=0100, seg=1111111 held 3 edges then changed → no commit. Hold seg=0001110 4 edges → digits[11:8]=F, digit_valid[2]=1.
- dig_sel=1000, seg=1010101 held 4 edges → err pulses 1 cycle, digit_valid[3]=0, digits[15:12] unchanged.
- Digit 1 valid with value 9, then dig_sel=0010, seg=1111111 held 4 edges → digit_valid[1]=0, no update, no err.
- dig_sel=0011, any seg held 8 edges → no output change. Sweep all 16 patterns on each digit → digits match table, 16 update pulses per digit.

Source files
------------

// File: rtl/leitor_7segmentos_pkg.sv
// Shared active-low seven-segment patterns (bit order g..a) used by both the
// display encoder and the segment reader, so the two tables cannot drift.
package leitor_7segmentos_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Indexed by the hex value it represents.
    localparam logic [6:0] SEG_TABLE [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };

endpackage

// File: rtl/segmentos_para_hex.sv
// Combinational reverse lookup: active-low segment pattern -> 4-bit hex value,
// flagging whether the pattern is a known digit or the all-off blank.
module segmentos_para_hex
    import leitor_7segmentos_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] valor,
    output logic       eh_valido,
    output logic       eh_branco
);

    always_comb begin
        valor     = 4'd0;
        eh_valido = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_TABLE[i]) begin
                valor     = 4'(i);
                eh_valido = 1'b1;
            end
        end
    end

    assign eh_branco = (seg == SEG_BLANK);

endmodule

// File: rtl/leitor_7segmentos.sv
// Seven-segment bus reader: waits for a stable {dig_sel, seg} pair, then
// decodes it once into the selected digit register with a valid flag.
module leitor_7segmentos
    import leitor_7segmentos_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    update,
    output logic                    err,
    output logic [IW-1:0]           last_idx
);

    localparam int         PW  = NUM_DIGITS + 7;
    localparam logic [3:0] SAT = 4'(STABLE_CYCLES - 1);

    logic [PW-1:0]           pair_q, pair_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    committed_q, committed_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic                    update_q, update_d;
    logic                    err_q, err_d;
    logic [IW-1:0]           last_idx_q, last_idx_d;

    logic [NUM_DIGITS-1:0]   sel_w;
    logic                    onehot_w;
    logic [IW-1:0]           idx_w;
    logic [3:0]              valor_w;
    logic                    eh_valido_w, eh_branco_w;
    logic                    same_w, commit_w;

    // Decode from the registered copy; it equals the live pair whenever a commit fires.
    segmentos_para_hex u_dec (
        .seg       (pair_q[6:0]),
        .valor     (valor_w),
        .eh_valido (eh_valido_w),
        .eh_branco (eh_branco_w)
    );

    assign pair_d   = {dig_sel, seg};
    assign same_w   = (pair_d == pair_q);
    assign sel_w    = pair_q[PW-1:7];
    assign onehot_w = (sel_w != '0) && ((sel_w & (sel_w - 1'b1)) == '0);

    always_comb begin
        idx_w = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_w[i]) idx_w = IW'(i);
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        committed_d = committed_q;
        commit_w    = 1'b0;
        if (same_w) begin
            if (cnt_q != SAT) cnt_d = cnt_q + 4'd1;
            // Fires on the SAT-1 -> SAT transition, at most once per stable window.
            if (cnt_q == SAT - 4'd1 && !committed_q) begin
                commit_w    = 1'b1;
                committed_d = 1'b1;
            end
        end else begin
            cnt_d       = 4'd0;
            committed_d = 1'b0;
        end
    end

    always_comb begin
        digits_d   = digits_q;
        valid_d    = valid_q;
        last_idx_d = last_idx_q;
        update_d   = 1'b0;
        err_d      = 1'b0;
        if (commit_w && onehot_w) begin
            last_idx_d = idx_w;
            if (eh_valido_w) begin
                digits_d[4*int'(idx_w) +: 4] = valor_w;
                valid_d[idx_w]               = 1'b1;
                update_d                     = 1'b1;
            end else begin
                valid_d[idx_w] = 1'b0;
                err_d          = !eh_branco_w;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_q      <= '0;
            cnt_q       <= 4'd0;
            committed_q <= 1'b0;
            digits_q    <= '0;
            valid_q     <= '0;
            update_q    <= 1'b0;
            err_q       <= 1'b0;
            last_idx_q  <= '0;
        end else begin
            pair_q      <= pair_d;
            cnt_q       <= cnt_d;
            committed_q <= committed_d;
            digits_q    <= digits_d;
            valid_q     <= valid_d;
            update_q    <= update_d;
            err_q       <= err_d;
            last_idx_q  <= last_idx_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign update      = update_q;
    assign err         = err_q;
    assign last_idx    = last_idx_q;

endmodule

// File: tb/tb_leitor_7segmentos.sv
// Directed bench for leitor_7segmentos: expected pulses are queued as stimulus
// is issued and a negedge monitor pops and compares on every update/err pulse.
module tb_leitor_7segmentos;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'd0;
    logic [3:0]  dig_sel = 4'd0;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        update;
    logic        err;
    logic [1:0]  last_idx;

    int errors = 0;
    int checks = 0;

    // Expected pulse record: {is_err, idx[1:0], digits[15:0], valid[3:0]}
    logic [22:0] exp_q[$];
    logic [15:0] m_digits = 16'd0;
    logic [3:0]  m_valid  = 4'd0;

    leitor_7segmentos #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .dig_sel     (dig_sel),
        .digits      (digits),
        .digit_valid (digit_valid),
        .update      (update),
        .err         (err),
        .last_idx    (last_idx)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [6:0] enc(input int v);
        case (v)
            0:  enc = 7'b1000000;  1:  enc = 7'b1111001;
            2:  enc = 7'b0100100;  3:  enc = 7'b0110000;
            4:  enc = 7'b0011001;  5:  enc = 7'b0010010;
            6:  enc = 7'b0000010;  7:  enc = 7'b1111000;
            8:  enc = 7'b0000000;  9:  enc = 7'b0010000;
            10: enc = 7'b0001000;  11: enc = 7'b0000011;
            12: enc = 7'b1000110;  13: enc = 7'b0100001;
            14: enc = 7'b0000110;  default: enc = 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic hold(input logic [3:0] s, input logic [6:0] g, input int n);
        dig_sel = s;
        seg     = g;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_update(input int idx, input int val);
        m_digits[idx*4 +: 4] = 4'(val);
        m_valid[idx]         = 1'b1;
        exp_q.push_back({1'b0, 2'(idx), m_digits, m_valid});
    endtask

    task automatic expect_err(input int idx);
        m_valid[idx] = 1'b0;
        exp_q.push_back({1'b1, 2'(idx), m_digits, m_valid});
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [22:0] e;
        forever begin
            @(negedge clk);
            if (!rst && (update || err)) begin
                chk("update_err_exclusive", {31'd0, update & err}, 32'd0);
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_pulse: got update=%0b err=%0b idx=%0d, required no pulse",
                             update, err, last_idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind_err",  {31'd0, err},         {31'd0, e[22]});
                    chk("pulse_last_idx",  {30'd0, last_idx},    {30'd0, e[21:20]});
                    chk("pulse_digits",    {16'd0, digits},      {16'd0, e[19:4]});
                    chk("pulse_valid",     {28'd0, digit_valid}, {28'd0, e[3:0]});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("reset_digits", {16'd0, digits}, 32'd0);
        chk("reset_valid",  {28'd0, digit_valid}, 32'd0);
        chk("reset_pulses", {30'd0, update, err}, 32'd0);
        chk("reset_idx",    {30'd0, last_idx}, 32'd0);
        rst = 1'b0;

        // Digit 0 <= 2; further holding must not pulse again.
        expect_update(0, 2);
        hold(4'b0001, 7'b0100100, 4);
        chk("d0_after_commit", {16'd0, digits}, 32'h0002);
        hold(4'b0001, 7'b0100100, 10);

        // Blank window cut short, then F on digit 2.
        hold(4'b0100, 7'b1111111, 3);
        expect_update(2, 15);
        hold(4'b0100, 7'b0001110, 4);

        // Illegal pattern on digit 3.
        expect_err(3);
        hold(4'b1000, 7'b1010101, 4);

        // Digit 1 <= 9, then blanked.
        expect_update(1, 9);
        hold(4'b0010, 7'b0010000, 4);
        m_valid[1] = 1'b0;
        hold(4'b0010, 7'b1111111, 4);
        chk("blank_valid", {28'd0, digit_valid}, {28'd0, m_valid});
        chk("blank_digits_kept", {16'd0, digits}, {16'd0, m_digits});
        chk("blank_last_idx", {30'd0, last_idx}, 32'd1);

        // Multi-hot select: window counts but nothing changes.
        hold(4'b0011, 7'b0100100, 8);
        chk("multihot_digits", {16'd0, digits}, {16'd0, m_digits});
        chk("multihot_valid",  {28'd0, digit_valid}, {28'd0, m_valid});
        chk("multihot_idx",    {30'd0, last_idx}, 32'd1);

        // Sweep all patterns on every digit.
        for (int d = 0; d < 4; d++) begin
            for (int v = 0; v < 16; v++) begin
                expect_update(d, v);
                hold(4'(1 << d), enc(v), 4);
            end
        end
        chk("sweep_digits", {16'd0, digits}, {16'd0, m_digits});
        chk("sweep_valid",  {28'd0, digit_valid}, 32'hF);

        // Asynchronous reset mid-window, then a fresh count.
        hold(4'b0001, enc(5), 2);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_digits", {16'd0, digits}, 32'd0);
        chk("async_rst_valid",  {28'd0, digit_valid}, 32'd0);
        chk("async_rst_idx",    {30'd0, last_idx}, 32'd0);
        m_digits = 16'd0;
        m_valid  = 4'd0;
        @(posedge clk);
        #2 rst = 1'b0;
        expect_update(0, 5);
        hold(4'b0001, enc(5), 3);
        chk("post_rst_no_early_commit", {31'd0, digit_valid[0]}, 32'd0);
        hold(4'b0001, enc(5), 1);

        repeat (3) @(posedge clk);
        #2;
        chk("exp_q_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
